// File: rtl/feat_buf_pkg.sv
// Shared types and default sizes for the feature-map buffer.
package feat_buf_pkg;

  // Controller states: IDLE serves the ports, CLEAR zero-fills the array.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } feat_buf_state_t;

  localparam int FB_DATA_W_DEF = 8;
  localparam int FB_DEPTH_DEF  = 16;

endpackage : feat_buf_pkg

// File: rtl/feat_buf_ram.sv
// Simple dual-port storage: one write port, one registered read-first port.
module feat_buf_ram
  import feat_buf_pkg::*;
#(
  parameter int  DATA_W = FB_DATA_W_DEF,
  parameter int  DEPTH  = FB_DEPTH_DEF,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array write port.
  // NOTE: the storage array has no reset; the clear sweep zeroes it, and
  // leaving it out of reset lets the tools map it onto RAM macros.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; returns the pre-write word on an address collision.
  // NOTE: non-blocking assignment samples mem before this edge's write lands,
  // which is exactly what makes the port read-first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule : feat_buf_ram

// File: rtl/feat_buf.sv
// Feature-map buffer top: clear sequencer, range checks, read strobe, error flag.
module feat_buf
  import feat_buf_pkg::*;
#(
  parameter int  DATA_W = FB_DATA_W_DEF,
  parameter int  DEPTH  = FB_DEPTH_DEF,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clr_req,
  output logic              busy,
  output logic              addr_err
);

  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

  feat_buf_state_t state, state_next;
  logic [AW-1:0]   ptr, ptr_next;

  logic              wr_in_range;
  logic              rd_in_range;
  logic              port_open;
  logic              wr_accept;
  logic              rd_accept;
  logic              range_fault;
  logic              clr_accept;
  logic              ram_we;
  logic [AW-1:0]     ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  // Range checks only cost logic when DEPTH leaves unused address codes.
  if (DEPTH == (1 << AW)) begin : g_pow2
    assign wr_in_range = 1'b1;
    assign rd_in_range = 1'b1;
  end else begin : g_npow2
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
  end

  // State and sweep pointer; reset lands in CLEAR so the array is zeroed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // Next-state logic and FSM-derived controls.
  // NOTE: every output of this block gets a default first so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    busy       = 1'b0;
    port_open  = 1'b0;
    clr_accept = 1'b0;
    case (state)
      ST_CLEAR: begin
        busy = 1'b1;
        if (ptr == PTR_LAST) begin
          state_next = ST_IDLE;
        end else begin
          ptr_next = ptr + AW'(1);
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          clr_accept = 1'b1;
          state_next = ST_CLEAR;
          ptr_next   = '0;
        end else begin
          port_open = 1'b1;
        end
      end
      default: begin
        state_next = ST_CLEAR;
        ptr_next   = '0;
      end
    endcase
  end

  // Port qualification: only in IDLE with no clear request pending.
  assign wr_accept   = port_open && wr_en && wr_in_range;
  assign rd_accept   = port_open && rd_en && rd_in_range;
  assign range_fault = port_open && ((wr_en && !wr_in_range) || (rd_en && !rd_in_range));

  // The sweep owns the write port while busy; otherwise the user write does.
  assign ram_we    = busy || wr_accept;
  assign ram_waddr = busy ? ptr : wr_addr;
  assign ram_wdata = busy ? '0  : wr_data;

  feat_buf_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (rd_accept),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // One-cycle strobe marking the word loaded by an accepted read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
    end
  end

  // Sticky address error; only an accepted clear (or reset) drops it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_err <= 1'b0;
    end else if (clr_accept) begin
      addr_err <= 1'b0;
    end else if (range_fault) begin
      addr_err <= 1'b1;
    end
  end

endmodule : feat_buf

// File: doc/feat_buf.md
# feat_buf

Parametrised single-clock feature-map buffer for the CNN datapath, replacing fixed 8×8 scratch memories between convolution stages. It provides independent write and read ports with a registered one-cycle read, and a `rd_valid` strobe. A hardware clear sequencer zeroes the array after reset or on request, so the storage array itself needs no reset. A sticky address-error flag covers non-power-of-two depths.

## Interface
- `DATA_W`, 8, word width in bits.
- `DEPTH`, 16, number of words; any value ≥ 2, not necessarily a power of two.
- `AW`, derived local `$clog2(DEPTH)`, address width; not overridable.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `wr_en`  in  1  write request.
- `wr_addr`  in  AW  write address.
- `wr_data`  in  DATA_W  write data.
- `rd_en`  in  1  read request.
- `rd_addr`  in  AW  read address.
- `rd_data`  out  DATA_W  registered read data.
- `rd_valid`  out  1  one-cycle strobe; `rd_data` is valid for the accepted read.
- `clr_req`  in  1  request a zero-fill of the whole array.
- `busy`  out  1  clear sweep in progress; all accesses are ignored.
- `addr_err`  out  1  sticky flag set by an out-of-range access.

## Operation
- **Reset values:**
  - `rd_data` = 0, `rd_valid` = 0, `addr_err` = 0.
  - `busy` = 1; the FSM is in CLEAR with the sweep pointer at 0.
  - Array contents are undefined until the sweep completes.
- **FSM states:** CLEAR and IDLE.
  - CLEAR: writes 0 to address `ptr` each cycle and increments `ptr`. When `ptr` = DEPTH-1 has been written, it moves to IDLE.
  - IDLE → CLEAR when `clr_req` = 1; `ptr` loads 0.
- **Behaviour in CLEAR:**
  - `wr_en`, `rd_en` and `clr_req` are ignored; the sweep is not restarted.
  - `rd_valid` = 0 and `rd_data` holds its value.
- **Priority in IDLE:** `clr_req` beats both ports.
  - A write or read in the same cycle as `clr_req` is dropped.
  - `addr_err` clears on that `clr_req`.
- **Write:** with `wr_en` = 1 and `wr_addr` < DEPTH, the array stores `wr_data`.
- **Read:** with `rd_en` = 1 and `rd_addr` < DEPTH, `rd_data` loads the array word and `rd_valid` pulses.
- **Simultaneous read and write:**
  - Different addresses: both are performed.
  - Same address: read-first; `rd_data` returns the old contents.
- **Out-of-range address (≥ DEPTH):**
  - The access is dropped; the array is unchanged and there is no `rd_valid`.
  - `addr_err` is set and stays set until reset or an accepted `clr_req`.
  - For power-of-two DEPTH this case is unreachable.
- **Width rules:**
  - `wr_data` is stored unmodified.
  - `ptr` is AW bits and never wraps past DEPTH-1.

## Timing
- **Read latency:** `rd_en` sampled at edge N → `rd_data`/`rd_valid` updated at edge N; visible in cycle N+1.
  - `rd_valid` is high for exactly one cycle per accepted read.
  - Back-to-back reads give one word per cycle.
- **Write visibility:** data written at edge N is readable by a read sampled at edge N+1.
- **Clear request:** `clr_req` sampled at edge N → `busy` = 1 from edge N.
  - Zeros are written at edges N+1 … N+DEPTH.
  - `busy` = 0 after edge N+DEPTH.
  - The first access is accepted at edge N+DEPTH+1.
- **After reset deassertion:** `busy` stays high for exactly DEPTH rising edges.
- **Reset mid-sweep or mid-read:**
  - All outputs return to their reset values immediately.
  - The sweep restarts from address 0.

## Structure
- Package `feat_buf_pkg` holds:
  - the state enum `feat_buf_state_t` {ST_IDLE, ST_CLEAR};
  - default constants `FB_DATA_W_DEF` = 8 and `FB_DEPTH_DEF` = 16.
- Sub-module `feat_buf_ram`: simple dual-port array (one write port, one registered read port, read-first, no reset), parametrised by DATA_W/DEPTH.
- The top level owns the FSM, the clear mux onto the write port, range checks, `rd_valid` and `addr_err`.

## Test plan
- **Reset sweep:** hold reset low, release; DEPTH=16.
  - Expect `busy` = 1 for 16 edges.
  - Then read addresses 0–15: every `rd_data` = 0x00, `rd_valid` one cycle after each `rd_en`.
- **Write/read:** write 0xA5 to address 3, then read address 3 next cycle.
  - Expect `rd_data` = 0xA5, `rd_valid` = 1 for one cycle.
  - Back-to-back reads of 0–15 stream one word per cycle.
- **Collision:** address 7 holds 0x11; in one cycle write 0x22 to 7 and read 7.
  - Expect `rd_data` = 0x11.
  - A read the next cycle returns 0x22.
- **Clear priority:** `clr_req` together with a write of 0xFF to address 2.
  - Expect `busy` for 16 cycles; accesses during `busy` are ignored (`rd_valid` stays 0).
  - Afterwards address 2 reads 0x00.
- **Range error:** DEPTH=12; write to address 13 and read address 14.
  - Expect no array change, no `rd_valid`, `addr_err` = 1 held.
  - A subsequent `clr_req` returns `addr_err` to 0.
- **Reset mid-sweep:** assert reset at sweep cycle 5, release.
  - Expect a full 16-cycle `busy` from the release.
  - Outputs return to reset values while reset is low.
